// File: rtl/aes_inv_round_mix.sv
// AES-128 decrypt round stage: AddRoundKey, then InvMixColumns except on the final beat of a block.
// One-cycle latency into a single output slot; in_ready = !out_valid || out_ready, so a stall holds the slot.
module aes_inv_round_mix #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0][3:0][7:0]  state_in,
    input  logic [3:0][3:0][7:0]  roundkey_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0][3:0][7:0]  state_out,
    output logic                  out_last,
    output logic [3:0]            out_round
);

    if (NR < 2 || NR > 15) begin : g_bad_nr
        $error("NR must be in 2..15");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Products by 9, 11, 13 and 14 all built from the x2/x4/x8 doubling chain.
    function automatic logic [3:0][7:0] inv_mix_column(input logic [3:0][7:0] a);
        logic [3:0][7:0] x2, x4, x8, m9, m11, m13, m14;
        logic [3:0][7:0] o;
        for (int r = 0; r < 4; r++) begin
            x2[r]  = xtime(a[r]);
            x4[r]  = xtime(x2[r]);
            x8[r]  = xtime(x4[r]);
            m9[r]  = x8[r] ^ a[r];
            m11[r] = x8[r] ^ x2[r] ^ a[r];
            m13[r] = x8[r] ^ x4[r] ^ a[r];
            m14[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        o[0] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
        o[1] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
        o[2] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
        o[3] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
        return o;
    endfunction

    logic [3:0]            rcnt;
    logic                  accept;
    logic                  is_last;
    logic [3:0][3:0][7:0]  keyed;
    logic [3:0][3:0][7:0]  mixed;
    logic [3:0][3:0][7:0]  result;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign keyed    = state_in ^ roundkey_in;
    assign is_last  = (rcnt == LAST_ROUND);
    assign result   = is_last ? keyed : mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [3:0][7:0] col_k;
        logic [3:0][7:0] col_m;
        assign col_k = {keyed[3][c], keyed[2][c], keyed[1][c], keyed[0][c]};
        assign col_m = inv_mix_column(col_k);
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign mixed[r][c] = col_m[r];
        end
    end

    // An accept in the same cycle as a drain simply overwrites the slot, keeping out_valid high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            state_out <= '0;
            out_last  <= 1'b0;
            out_round <= 4'd0;
            rcnt      <= 4'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            state_out <= result;
            out_last  <= is_last;
            out_round <= rcnt;
            rcnt      <= is_last ? 4'd0 : rcnt + 4'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_inv_round_mix.sv
// Randomized scoreboard bench for aes_inv_round_mix with a GF(2^8) polynomial reference model.
module tb_aes_inv_round_mix;

    localparam int NR = 10;

    typedef logic [3:0][3:0][7:0] st_t;
    typedef struct {
        st_t        st;
        logic [3:0] round;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    st_t        state_in = '0;
    st_t        roundkey_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    st_t        state_out;
    logic       out_last;
    logic [3:0] out_round;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   mbeat = 0;
    int   rdy_mode = 0;

    aes_inv_round_mix #(.NR(NR)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .roundkey_in(roundkey_in), .out_valid(out_valid),
        .out_ready(out_ready), .state_out(state_out), .out_last(out_last),
        .out_round(out_round)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Carry-less product followed by polynomial reduction modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--)
            if (p[i]) p ^= 16'h011B << (i - 8);
        return p[7:0];
    endfunction

    function automatic st_t ref_model(input st_t s, input st_t k, input int beat);
        logic [7:0] m [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                 '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
        st_t x = s ^ k;
        st_t o = '0;
        if (beat == NR - 1) return x;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    o[r][c] ^= gmul(m[r][j], x[j][c]);
        return o;
    endfunction

    function automatic st_t rand_st();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_beat(input st_t s, input st_t k);
        int  n = 0;
        bit  done = 0;
        exp_t e;
        in_valid = 1'b1;
        state_in = s;
        roundkey_in = k;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.st = ref_model(s, k, mbeat);
                e.round = 4'(mbeat);
                e.last = (mbeat == NR - 1);
                sb.push_back(e);
                mbeat = (mbeat == NR - 1) ? 0 : mbeat + 1;
                done = 1;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                check("accept_timeout", 128'd0, 128'd1);
                done = 1;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        sb.delete();
        mbeat = 0;
        #1 reset_n = 1'b1;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_last", 128'(out_last), 128'd0);
        check("rst_out_round", 128'(out_round), 128'd0);
        check("rst_state_out", state_out, 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every output handshake, checks stall stability and in_ready.
    initial begin
        exp_t e;
        bit   stalled = 0;
        st_t  held_st;
        logic [3:0] held_round;
        logic held_last;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 0;
            end else begin
                check("in_ready_comb", 128'(in_ready), 128'(!out_valid || out_ready));
                if (stalled) begin
                    check("stall_valid", 128'(out_valid), 128'd1);
                    check("stall_state", state_out, held_st);
                    check("stall_round", 128'(out_round), 128'(held_round));
                    check("stall_last", 128'(out_last), 128'(held_last));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 128'd1, 128'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_state", state_out, e.st);
                        check("sb_round", 128'(out_round), 128'(e.round));
                        check("sb_last", 128'(out_last), 128'(e.last));
                    end
                end
                stalled = out_valid && !out_ready;
                held_st = state_out;
                held_round = out_round;
                held_last = out_last;
            end
        end
    end

    initial begin
        st_t s, k, held;
        int  n;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_reset_state();

        // Known InvMixColumns vectors on beat 0 with a zero key.
        s = '0;
        k = '0;
        s[0][0] = 8'h8E; s[1][0] = 8'h4D; s[2][0] = 8'hA1; s[3][0] = 8'hBC;
        s[0][1] = 8'h9F; s[1][1] = 8'hDC; s[2][1] = 8'h58; s[3][1] = 8'h9D;
        for (int r = 0; r < 4; r++) begin
            s[r][2] = 8'h01;
            s[r][3] = 8'h01;
        end
        send_beat(s, k);
        in_valid = 1'b0;
        @(negedge clk);
        check("imc_valid", 128'(out_valid), 128'd1);
        check("imc_col0", {state_out[0][0], state_out[1][0], state_out[2][0], state_out[3][0]}, 128'hDB135345);
        check("imc_col1", {state_out[0][1], state_out[1][1], state_out[2][1], state_out[3][1]}, 128'hF20A225C);
        check("imc_col2", {state_out[0][2], state_out[1][2], state_out[2][2], state_out[3][2]}, 128'h01010101);
        check("imc_col3", {state_out[0][3], state_out[1][3], state_out[2][3], state_out[3][3]}, 128'h01010101);
        check("imc_round", 128'(out_round), 128'd0);
        check("imc_last", 128'(out_last), 128'd0);
        @(posedge clk); #1;

        // Key is added before the mix (beat 1).
        s = '0;
        k = '0;
        s[0][0] = 8'h8E ^ 8'h11; s[1][0] = 8'h4D ^ 8'h22; s[2][0] = 8'hA1 ^ 8'h33; s[3][0] = 8'hBC ^ 8'h44;
        k[0][0] = 8'h11; k[1][0] = 8'h22; k[2][0] = 8'h33; k[3][0] = 8'h44;
        send_beat(s, k);
        in_valid = 1'b0;
        @(negedge clk);
        check("key_mix_col0", {state_out[0][0], state_out[1][0], state_out[2][0], state_out[3][0]}, 128'hDB135345);
        @(posedge clk); #1;

        // Beats 2..8 back to back, then the final AddRoundKey-only beat.
        for (int b = 2; b < NR - 1; b++) send_beat(rand_st(), rand_st());
        send_beat('0, {16{8'hA5}});
        in_valid = 1'b0;
        @(negedge clk);
        check("final_state", state_out, {16{8'hA5}});
        check("final_last", 128'(out_last), 128'd1);
        check("final_round", 128'(out_round), 128'd9);
        @(posedge clk); #1;
        send_beat(rand_st(), rand_st());
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap_round", 128'(out_round), 128'd0);
        check("wrap_last", 128'(out_last), 128'd0);
        @(posedge clk); #1;

        // Backpressure: one beat in, then four cycles of stall with in_valid held.
        repeat (2) @(posedge clk);
        #1;
        rdy_mode = 2;
        out_ready = 1'b0;
        send_beat(rand_st(), rand_st());
        s = rand_st();
        k = rand_st();
        state_in = s;
        roundkey_in = k;
        in_valid = 1'b1;
        @(negedge clk);
        held = state_out;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_state", state_out, held);
        end
        @(posedge clk); #1;
        rdy_mode = 0;
        out_ready = 1'b1;
        send_beat(s, k);
        send_beat(rand_st(), rand_st());

        // Randomized traffic with random output backpressure and input gaps.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                send_beat(rand_st(), rand_st());
            end
        end
        in_valid = 1'b0;

        // Reset mid-block after beats 0..4.
        rdy_mode = 0;
        do_reset(1);
        for (int b = 0; b < 5; b++) send_beat(rand_st(), rand_st());
        in_valid = 1'b0;
        do_reset(1);
        @(negedge clk);
        check("midrst_valid", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        send_beat(rand_st(), rand_st());
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_round", 128'(out_round), 128'd0);
        @(posedge clk); #1;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
